// File: rtl/mem_sram_access.sv
// MEM-stage load/store engine driving a 32-bit asynchronous SRAM with byte enables.
// Each access holds the pipeline through stall_req for a fixed number of wait states.
module mem_sram_access #(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        mem_wd,
   input  logic              mem_wreg,
   input  logic [31:0]       mem_wdata,
   input  logic [7:0]        mem_aluop,
   input  logic [31:0]       mem_mem_addr,
   input  logic [31:0]       mem_reg2,
   output logic [4:0]        wb_wd,
   output logic              wb_wreg,
   output logic [31:0]       wb_wdata,
   output logic              stall_req,
   output logic              exc_adel,
   output logic              exc_ades,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_dout,
   input  logic [31:0]       sram_din,
   output logic              sram_dout_en,
   output logic [3:0]        sram_be_n,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, READ, WRITE, WREC, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [31:0]      rd_buf;

   logic is_load;
   logic is_store;
   logic misaligned;
   logic go;

   logic unused_addr_hi;
   assign unused_addr_hi = ^mem_mem_addr[31:ADDR_W+2];

   function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [1:0] lo,
                                               input logic [31:0] word);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (op)
         EXE_LB_OP:  load_extend = 32'(b);
         EXE_LBU_OP: load_extend = {24'd0, b};
         EXE_LH_OP:  load_extend = 32'(h);
         EXE_LHU_OP: load_extend = {16'd0, h};
         default:    load_extend = word;
      endcase
   endfunction

   function automatic logic [3:0] store_be_n(input logic [7:0] op, input logic [1:0] lo);
      case (op)
         EXE_SB_OP: store_be_n = ~(4'b0001 << lo);
         EXE_SH_OP: store_be_n = lo[1] ? 4'b0011 : 4'b1100;
         default:   store_be_n = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] data);
      case (op)
         EXE_SB_OP: store_data = {4{data[7:0]}};
         EXE_SH_OP: store_data = {2{data[15:0]}};
         default:   store_data = data;
      endcase
   endfunction

   always_comb begin
      is_load    = 1'b0;
      is_store   = 1'b0;
      misaligned = 1'b0;
      case (mem_aluop)
         EXE_LB_OP, EXE_LBU_OP: is_load = 1'b1;
         EXE_LH_OP, EXE_LHU_OP: begin
            is_load    = 1'b1;
            misaligned = mem_mem_addr[0];
         end
         EXE_LW_OP: begin
            is_load    = 1'b1;
            misaligned = |mem_mem_addr[1:0];
         end
         EXE_SB_OP: is_store = 1'b1;
         EXE_SH_OP: begin
            is_store   = 1'b1;
            misaligned = mem_mem_addr[0];
         end
         EXE_SW_OP: begin
            is_store   = 1'b1;
            misaligned = |mem_mem_addr[1:0];
         end
         default: ;
      endcase
   end

   assign go = (is_load | is_store) & ~misaligned;

   // Write-back and stall are decoded from the current state plus the held EX/MEM request.
   always_comb begin
      wb_wd     = mem_wd;
      wb_wreg   = mem_wreg;
      wb_wdata  = mem_wdata;
      stall_req = 1'b0;
      exc_adel  = 1'b0;
      exc_ades  = 1'b0;
      if (rst) begin
         case (state)
            IDLE: begin
               if (go) begin
                  stall_req = 1'b1;
                  wb_wreg   = 1'b0;
               end else if (misaligned) begin
                  exc_adel = is_load;
                  exc_ades = is_store;
                  wb_wreg  = 1'b0;
               end
            end
            READ, WRITE, WREC: begin
               stall_req = 1'b1;
               wb_wreg   = 1'b0;
            end
            DONE: begin
               if (is_store)
                  wb_wreg = 1'b0;
               else
                  wb_wdata = load_extend(mem_aluop, mem_mem_addr[1:0], rd_buf);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         rd_buf       <= '0;
         sram_addr    <= '0;
         sram_dout    <= '0;
         sram_dout_en <= 1'b0;
         sram_be_n    <= 4'hF;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  sram_addr <= mem_mem_addr[ADDR_W+1:2];
                  sram_ce_n <= 1'b0;
                  wait_cnt  <= '0;
                  if (is_load) begin
                     sram_be_n <= 4'h0;
                     sram_oe_n <= 1'b0;
                     state     <= READ;
                  end else begin
                     sram_be_n    <= store_be_n(mem_aluop, mem_mem_addr[1:0]);
                     sram_dout    <= store_data(mem_aluop, mem_reg2);
                     sram_we_n    <= 1'b0;
                     sram_dout_en <= 1'b1;
                     state        <= WRITE;
                  end
               end
            end
            READ: begin
               if (wait_cnt == CNT_LAST) begin
                  rd_buf    <= sram_din;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_be_n <= 4'hF;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WRITE: begin
               if (wait_cnt == CNT_LAST) begin
                  sram_we_n <= 1'b1;
                  state     <= WREC;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            // Data, address and lanes stay driven one cycle past we_n rising for hold time.
            WREC: begin
               sram_ce_n    <= 1'b1;
               sram_dout_en <= 1'b0;
               sram_be_n    <= 4'hF;
               state        <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_access.sv
// Table-driven bench for mem_sram_access: each vector is queued as expected
// results when driven and compared once the access reaches its final cycle.
module tb_mem_sram_access;

   localparam int W = 2;

   localparam logic [7:0] LB  = 8'b1110_0000;
   localparam logic [7:0] LH  = 8'b1110_0001;
   localparam logic [7:0] LW  = 8'b1110_0011;
   localparam logic [7:0] LBU = 8'b1110_0100;
   localparam logic [7:0] LHU = 8'b1110_0101;
   localparam logic [7:0] SB  = 8'b1110_1000;
   localparam logic [7:0] SH  = 8'b1110_1001;
   localparam logic [7:0] SW  = 8'b1110_1011;
   localparam logic [7:0] ADD = 8'b0010_0001;

   logic        clk;
   logic        rst;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr;
   logic [31:0] mem_reg2;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        stall_req;
   logic        exc_adel;
   logic        exc_ades;
   logic [19:0] sram_addr;
   logic [31:0] sram_dout;
   logic [31:0] sram_din;
   logic        sram_dout_en;
   logic [3:0]  sram_be_n;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;

   logic [31:0] rd_word;
   int          n_vec;
   int          n_bad;

   mem_sram_access #(.WAIT_CYCLES(W), .ADDR_W(20)) dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .stall_req(stall_req), .exc_adel(exc_adel), .exc_ades(exc_ades),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
      .sram_dout_en(sram_dout_en), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   // SRAM only drives valid data while selected and output-enabled.
   assign sram_din = (!sram_ce_n && !sram_oe_n) ? rd_word : 32'h5A5A_5A5A;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] reg2;
      logic [31:0] din;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        x_wreg;
      logic [31:0] x_wdata;
      logic        chk_wdata;
      logic        x_adel;
      logic        x_ades;
      int          x_stall;
      int          x_ce;
      int          x_oe;
      int          x_we;
      int          x_den;
      logic [19:0] x_saddr;
      logic [3:0]  x_be;
      logic [31:0] x_dout;
      logic        chk_dout;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t blank(input logic [7:0] op, input logic [31:0] a, input logic [4:0] wd);
      vec_t v;
      v.op = op; v.addr = a; v.reg2 = 32'h0BAD_0BAD; v.din = 32'h0;
      v.wd = wd; v.wreg = 1'b1; v.wdata = 32'h7777_7777;
      v.x_wreg = 1'b0; v.x_wdata = 32'h0; v.chk_wdata = 1'b0;
      v.x_adel = 1'b0; v.x_ades = 1'b0;
      v.x_stall = 0; v.x_ce = 0; v.x_oe = 0; v.x_we = 0; v.x_den = 0;
      v.x_saddr = 20'h0; v.x_be = 4'h0; v.x_dout = 32'h0; v.chk_dout = 1'b0;
      return v;
   endfunction

   function automatic vec_t ld(input logic [7:0] op, input logic [31:0] a, input logic [31:0] din,
                               input logic [31:0] xw, input logic [19:0] sa, input logic [4:0] wd);
      vec_t v;
      v = blank(op, a, wd);
      v.din = din; v.x_wreg = 1'b1; v.x_wdata = xw; v.chk_wdata = 1'b1;
      v.x_stall = W + 1; v.x_ce = W; v.x_oe = W; v.x_saddr = sa; v.x_be = 4'h0;
      return v;
   endfunction

   function automatic vec_t st(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                               input logic [31:0] xd, input logic [3:0] be, input logic [19:0] sa);
      vec_t v;
      v = blank(op, a, 5'd12);
      v.reg2 = r2; v.x_stall = W + 2; v.x_ce = W + 1; v.x_we = W; v.x_den = W + 1;
      v.x_saddr = sa; v.x_be = be; v.x_dout = xd; v.chk_dout = 1'b1;
      return v;
   endfunction

   function automatic vec_t bad(input logic [7:0] op, input logic [31:0] a,
                                input logic adel, input logic ades);
      vec_t v;
      v = blank(op, a, 5'd20);
      v.x_adel = adel; v.x_ades = ades;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      mem_aluop    = v.op;
      mem_mem_addr = v.addr;
      mem_reg2     = v.reg2;
      mem_wd       = v.wd;
      mem_wreg     = v.wreg;
      mem_wdata    = v.wdata;
      rd_word      = v.din;
   endtask

   // Called right at a falling edge; returns at the falling edge after the final cycle.
   task automatic run_vec(input vec_t v);
      vec_t        x;
      int          cyc, n_st, n_ce, n_oe, n_we, n_den;
      logic [19:0] c_addr;
      logic [3:0]  c_be;
      logic [31:0] c_dout;
      drive(v);
      sb.push_back(v);
      cyc = 0; n_st = 0; n_ce = 0; n_oe = 0; n_we = 0; n_den = 0;
      c_addr = 20'hFFFFF; c_be = 4'hF; c_dout = 32'h0;
      #1;
      while (stall_req === 1'b1 && cyc < 20) begin
         n_st++;
         if (!sram_ce_n) begin
            n_ce++;
            c_addr = sram_addr;
            c_be   = sram_be_n;
            c_dout = sram_dout;
         end
         if (!sram_oe_n) n_oe++;
         if (!sram_we_n) n_we++;
         if (sram_dout_en) n_den++;
         @(negedge clk); #1;
         cyc++;
      end
      if (!sram_ce_n) n_ce++;
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) n_we++;
      if (sram_dout_en) n_den++;
      x = sb.pop_front();
      if (cyc >= 20) check("stall timeout", 32'(cyc), 32'd0);
      check("exc_adel", 32'(exc_adel), 32'(x.x_adel));
      check("exc_ades", 32'(exc_ades), 32'(x.x_ades));
      check("wb_wreg", 32'(wb_wreg), 32'(x.x_wreg));
      check("wb_wd", 32'(wb_wd), 32'(x.wd));
      if (x.chk_wdata) check("wb_wdata", wb_wdata, x.x_wdata);
      check("stall cycles", 32'(n_st), 32'(x.x_stall));
      check("ce_n low cycles", 32'(n_ce), 32'(x.x_ce));
      check("oe_n low cycles", 32'(n_oe), 32'(x.x_oe));
      check("we_n low cycles", 32'(n_we), 32'(x.x_we));
      check("dout_en cycles", 32'(n_den), 32'(x.x_den));
      if (x.x_ce > 0) begin
         check("sram_addr", 32'(c_addr), 32'(x.x_saddr));
         check("sram_be_n", 32'(c_be), 32'(x.x_be));
      end
      if (x.chk_dout) check("sram_dout", c_dout, x.x_dout);
      @(negedge clk);
   endtask

   initial begin
      vec_t alu, lw0;
      int   k;
      n_vec = 0;
      n_bad = 0;

      lw0 = ld(LW, 32'h8000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 20'h00004, 5'd3);
      tbl.push_back(lw0);
      tbl.push_back(st(SW, 32'h8000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b0000, 20'h00041));
      tbl.push_back(ld(LB,  32'h8000_0013, 32'h80FF_1234, 32'hFFFF_FF80, 20'h00004, 5'd4));
      tbl.push_back(ld(LBU, 32'h8000_0013, 32'h80FF_1234, 32'h0000_0080, 20'h00004, 5'd5));
      tbl.push_back(ld(LB,  32'h8000_0011, 32'h80FF_1234, 32'h0000_0012, 20'h00004, 5'd6));
      tbl.push_back(ld(LB,  32'h8000_0012, 32'h80FF_1234, 32'hFFFF_FFFF, 20'h00004, 5'd7));
      tbl.push_back(ld(LH,  32'h8000_0002, 32'h80FF_1234, 32'hFFFF_80FF, 20'h00000, 5'd8));
      tbl.push_back(ld(LHU, 32'h8000_0002, 32'h80FF_1234, 32'h0000_80FF, 20'h00000, 5'd9));
      tbl.push_back(ld(LH,  32'h8000_0000, 32'h1234_8001, 32'hFFFF_8001, 20'h00000, 5'd10));
      tbl.push_back(ld(LHU, 32'h8000_0000, 32'h1234_8001, 32'h0000_8001, 20'h00000, 5'd11));
      tbl.push_back(st(SH, 32'h8000_0002, 32'h0000_ABCD, 32'hABCD_ABCD, 4'b0011, 20'h00000));
      tbl.push_back(st(SH, 32'h8000_0000, 32'hFFFF_1357, 32'h1357_1357, 4'b1100, 20'h00000));
      tbl.push_back(st(SB, 32'h8000_0021, 32'h1234_56EF, 32'hEFEF_EFEF, 4'b1101, 20'h00008));
      tbl.push_back(st(SB, 32'h8000_0023, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b0111, 20'h00008));
      alu = blank(ADD, 32'h8000_0010, 5'd7);
      alu.wdata = 32'h1111_2222; alu.x_wreg = 1'b1; alu.x_wdata = 32'h1111_2222; alu.chk_wdata = 1'b1;
      tbl.push_back(alu);
      tbl.push_back(bad(LW, 32'h8000_0001, 1'b1, 1'b0));
      tbl.push_back(bad(SW, 32'h8000_0002, 1'b0, 1'b1));
      tbl.push_back(bad(LH, 32'h8000_0003, 1'b1, 1'b0));
      tbl.push_back(bad(SH, 32'h8000_0001, 1'b0, 1'b1));
      tbl.push_back(ld(LBU, 32'h8000_0010, 32'h80FF_1234, 32'h0000_0034, 20'h00004, 5'd13));

      // Reset with an aligned load presented: outputs idle, write-back passes through.
      rst = 1'b0;
      drive(lw0);
      mem_wdata = 32'h2468_ACE0;
      repeat (2) @(negedge clk);
      #1;
      check("rst ce_n", 32'(sram_ce_n), 32'd1);
      check("rst oe_n", 32'(sram_oe_n), 32'd1);
      check("rst we_n", 32'(sram_we_n), 32'd1);
      check("rst be_n", 32'(sram_be_n), 32'hF);
      check("rst dout_en", 32'(sram_dout_en), 32'd0);
      check("rst dout", sram_dout, 32'd0);
      check("rst addr", 32'(sram_addr), 32'd0);
      check("rst stall_req", 32'(stall_req), 32'd0);
      check("rst wb_wreg", 32'(wb_wreg), 32'd1);
      check("rst wb_wdata", wb_wdata, 32'h2468_ACE0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Asynchronous reset in the middle of a read aborts the access at once.
      drive(lw0);
      k = 0;
      #1;
      while (sram_oe_n && k < 10) begin
         @(negedge clk); #1;
         k++;
      end
      check("oe_n reached low", 32'(sram_oe_n), 32'd0);
      #2;
      rst = 1'b0;
      #1;
      check("abort ce_n", 32'(sram_ce_n), 32'd1);
      check("abort oe_n", 32'(sram_oe_n), 32'd1);
      check("abort stall_req", 32'(stall_req), 32'd0);
      check("abort be_n", 32'(sram_be_n), 32'hF);
      @(negedge clk);
      rst = 1'b1;
      run_vec(lw0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
